// File: rtl/rv64g_pkg.sv
// Shared RV64G decode/issue types.
//   NUM_REGS        : architectural registers tracked (x0-x31, f0-f31)
//   NUM_OUTSTANDING : default cap on issued-but-unretired register writers
//   decoded_instr_t : decoder output consumed by the issue scoreboard
//   issue_state_t   : issue FSM states
package rv64g_pkg;

  localparam int unsigned NUM_REGS        = 64;
  localparam int unsigned REG_IDX_W       = $clog2(NUM_REGS);
  localparam int unsigned NUM_OUTSTANDING = 7;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_JUMP,
    OP_FPU,
    OP_SYSTEM
  } op_class_t;

  // reg_req lists every register the instruction must not race with
  // (its sources and its destination); the decoder builds it.
  typedef struct packed {
    logic [63:0]          pc;
    logic [63:0]          imm;
    op_class_t            op;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rs3;
    logic [NUM_REGS-1:0]  reg_req;
    logic                 jump;
  } decoded_instr_t;

  typedef enum logic {
    ISSUE,
    BR_WAIT
  } issue_state_t;

endpackage

// File: rtl/rv64g_reg_lock_table.sv
// Register lock vector and outstanding-writer counter.
//   clk_i, arst_ni        : clock, asynchronous active-low reset
//   set_valid_i, set_rd_i : lock a destination register on issue (rd 0 ignored)
//   clr_valid_i, clr_rd_i : writeback release (ignored for unlocked registers)
//   locks_o               : current lock vector
//   outstanding_o         : number of locked, unretired writers
module rv64g_reg_lock_table
  import rv64g_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = NUM_OUTSTANDING
) (
  input  logic                                   clk_i,
  input  logic                                   arst_ni,
  input  logic                                   set_valid_i,
  input  logic [REG_IDX_W-1:0]                   set_rd_i,
  input  logic                                   clr_valid_i,
  input  logic [REG_IDX_W-1:0]                   clr_rd_i,
  output logic [NUM_REGS-1:0]                    locks_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] locks_q, locks_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                set_en, clr_en;

  assign set_en = set_valid_i && (set_rd_i != '0);
  assign clr_en = clr_valid_i && locks_q[clr_rd_i];

  // Set is applied after clear so a same-cycle lock/release of one
  // register leaves it locked.
  always_comb begin
    locks_d = locks_q;
    if (clr_en) locks_d[clr_rd_i] = 1'b0;
    if (set_en) locks_d[set_rd_i] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({set_en, clr_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      locks_q <= '0;
      cnt_q   <= '0;
    end else begin
      locks_q <= locks_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locks_o       = locks_q;
  assign outstanding_o = cnt_q;

endmodule

// File: rtl/rv64g_issue_scoreboard.sv
// In-order issue stage with a one-entry holding register and register
// scoreboard.
//   clk_i, arst_ni                       : clock, asynchronous active-low reset
//   instr_in_i/_valid_i/_ready_o         : decoder-side handshake
//   instr_out_o/_valid_o/_ready_i        : execute-side handshake
//   wb_valid_i, wb_rd_i                  : writeback release of a register
//   br_done_i                            : issued jump/branch resolved
//   flush_i                              : discard the held, unissued instruction
//   locks_o, outstanding_o               : scoreboard state
module rv64g_issue_scoreboard
  import rv64g_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = NUM_OUTSTANDING
) (
  input  logic                                   clk_i,
  input  logic                                   arst_ni,
  input  decoded_instr_t                         instr_in_i,
  input  logic                                   instr_in_valid_i,
  output logic                                   instr_in_ready_o,
  output decoded_instr_t                         instr_out_o,
  output logic                                   instr_out_valid_o,
  input  logic                                   instr_out_ready_i,
  input  logic                                   wb_valid_i,
  input  logic [5:0]                             wb_rd_i,
  input  logic                                   br_done_i,
  input  logic                                   flush_i,
  output logic [NUM_REGS-1:0]                    locks_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned    CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  issue_state_t   state_q, state_d;
  logic           hold_valid_q, hold_valid_d;
  decoded_instr_t hold_instr_q, hold_instr_d;

  logic             in_fire, out_fire;
  logic [NUM_REGS-1:0] locks;
  logic [CNT_W-1:0] outstanding;

  rv64g_reg_lock_table #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_lock_table (
    .clk_i         (clk_i),
    .arst_ni       (arst_ni),
    .set_valid_i   (out_fire),
    .set_rd_i      (hold_instr_q.rd),
    .clr_valid_i   (wb_valid_i),
    .clr_rd_i      (wb_rd_i),
    .locks_o       (locks),
    .outstanding_o (outstanding)
  );

  // Issue decision uses registered state only, so a release is visible
  // one cycle later and no writeback-to-issue combinational path exists.
  assign instr_out_valid_o = hold_valid_q
                          && (state_q == ISSUE)
                          && ((hold_instr_q.reg_req & locks) == '0)
                          && (outstanding < MAX_CNT)
                          && (!hold_instr_q.jump || (outstanding == '0));

  assign out_fire         = instr_out_valid_o && instr_out_ready_i;
  assign instr_in_ready_o = !flush_i && (!hold_valid_q || out_fire);
  assign in_fire          = instr_in_valid_i && instr_in_ready_o;

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;

    case (state_q)
      ISSUE:   if (out_fire && hold_instr_q.jump) state_d = BR_WAIT;
      BR_WAIT: if (br_done_i) state_d = ISSUE;
      default: state_d = ISSUE;
    endcase

    if (out_fire) hold_valid_d = 1'b0;
    if (in_fire) begin
      hold_valid_d = 1'b1;
      hold_instr_d = instr_in_i;
    end

    if (flush_i) begin
      hold_valid_d = 1'b0;
      state_d      = ISSUE;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= ISSUE;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign instr_out_o   = hold_instr_q;
  assign locks_o       = locks;
  assign outstanding_o = outstanding;

endmodule

// File: tb/tb_rv64g_issue_scoreboard.sv
module tb_rv64g_issue_scoreboard;
  import rv64g_pkg::*;

  logic           clk;
  logic           arst_ni;
  decoded_instr_t instr_in;
  logic           in_valid, in_ready;
  decoded_instr_t instr_out;
  logic           out_valid, out_ready;
  logic           wb_valid;
  logic [5:0]     wb_rd;
  logic           br_done, flush;
  logic [NUM_REGS-1:0] locks;
  logic [2:0]     outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  rv64g_issue_scoreboard #(.MAX_OUTSTANDING(7)) dut (
    .clk_i             (clk),
    .arst_ni           (arst_ni),
    .instr_in_i        (instr_in),
    .instr_in_valid_i  (in_valid),
    .instr_in_ready_o  (in_ready),
    .instr_out_o       (instr_out),
    .instr_out_valid_o (out_valid),
    .instr_out_ready_i (out_ready),
    .wb_valid_i        (wb_valid),
    .wb_rd_i           (wb_rd),
    .br_done_i         (br_done),
    .flush_i           (flush),
    .locks_o           (locks),
    .outstanding_o     (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic decoded_instr_t mk(int rd, int rs1, int rs2, bit jump);
    decoded_instr_t d;
    d = '0;
    d.rd   = 6'(rd);
    d.rs1  = 6'(rs1);
    d.rs2  = 6'(rs2);
    d.jump = jump;
    d.op   = jump ? OP_BRANCH : OP_ALU;
    d.imm  = 64'(rd * 16 + 1);
    d.pc   = 64'h8000_0000 + 64'(rd * 4);
    if (rs1 != 0) d.reg_req[rs1] = 1'b1;
    if (rs2 != 0) d.reg_req[rs2] = 1'b1;
    if (rd != 0)  d.reg_req[rd]  = 1'b1;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wb_pulse(input int r);
    wb_valid = 1'b1;
    wb_rd    = 6'(r);
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    arst_ni = 1'b0; in_valid = 1'b0; instr_in = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; br_done = 1'b0; flush = 1'b0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_locks", locks, 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_instr_out_zero", 64'(instr_out === '0), 64'd1);

    // back-to-back independent issue; first acceptance on first edge after release
    instr_in = mk(5, 0, 0, 0); in_valid = 1'b1;
    @(negedge clk); arst_ni = 1'b1;
    #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
    tick();
    instr_in = mk(6, 0, 0, 0);
    sample();
    chk("b2b_valid5", 64'(out_valid), 64'd1);
    chk("b2b_rd5", 64'(instr_out.rd), 64'd5);
    chk("b2b_ready_full_thru", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    sample();
    chk("b2b_valid6", 64'(out_valid), 64'd1);
    chk("b2b_rd6", 64'(instr_out.rd), 64'd6);
    chk("b2b_locks_5", locks, 64'h20);
    tick();
    sample();
    chk("b2b_locks_56", locks, 64'h60);
    chk("b2b_outstanding", 64'(outstanding), 64'd2);
    chk("b2b_idle_valid", 64'(out_valid), 64'd0);
    wb_pulse(5);
    wb_pulse(6);
    sample();
    chk("b2b_drained", 64'(outstanding), 64'd0);
    chk("b2b_unlocked", locks, 64'd0);

    // RAW stall on x3
    instr_in = mk(3, 1, 2, 0); in_valid = 1'b1;
    tick();
    instr_in = mk(4, 3, 0, 0);
    tick();
    in_valid = 1'b0;
    sample();
    chk("raw_stall", 64'(out_valid), 64'd0);
    chk("raw_outstanding1", 64'(outstanding), 64'd1);
    tick();
    sample();
    chk("raw_stall2", 64'(out_valid), 64'd0);
    wb_valid = 1'b1; wb_rd = 6'd3;
    #1 chk("raw_no_bypass", 64'(out_valid), 64'd0);
    tick();
    wb_valid = 1'b0;
    sample();
    chk("raw_released_valid", 64'(out_valid), 64'd1);
    chk("raw_rd4", 64'(instr_out.rd), 64'd4);
    chk("raw_outstanding0", 64'(outstanding), 64'd0);
    tick();
    sample();
    chk("raw_outstanding1b", 64'(outstanding), 64'd1);
    chk("raw_locks4", locks, 64'h10);

    // simultaneous issue (x7) and release (x4)
    instr_in = mk(7, 0, 0, 0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 6'd4;
    sample();
    chk("sim_valid7", 64'(out_valid), 64'd1);
    tick();
    wb_valid = 1'b0;
    sample();
    chk("sim_outstanding_hold", 64'(outstanding), 64'd1);
    chk("sim_locks7", locks, 64'h80);
    wb_pulse(9);
    sample();
    chk("wb_unlocked_ignored", 64'(outstanding), 64'd1);
    chk("wb_unlocked_locks", locks, 64'h80);
    wb_pulse(7);
    sample();
    chk("sim_drained", 64'(outstanding), 64'd0);

    // outstanding cap
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      instr_in = mk(i, 0, 0, 0);
      tick();
    end
    in_valid = 1'b0;
    sample();
    chk("cap_outstanding7", 64'(outstanding), 64'd7);
    chk("cap_held", 64'(out_valid), 64'd0);
    chk("cap_in_ready", 64'(in_ready), 64'd0);
    chk("cap_locks", locks, 64'hFE);
    wb_valid = 1'b1; wb_rd = 6'd1;
    tick();
    wb_valid = 1'b0;
    sample();
    chk("cap_release_valid", 64'(out_valid), 64'd1);
    chk("cap_rd8", 64'(instr_out.rd), 64'd8);
    chk("cap_outstanding6", 64'(outstanding), 64'd6);
    tick();
    sample();
    chk("cap_outstanding7b", 64'(outstanding), 64'd7);
    for (int i = 2; i <= 8; i++) wb_pulse(i);
    sample();
    chk("cap_drained", 64'(outstanding), 64'd0);

    // jump waits for zero outstanding, then BR_WAIT
    in_valid = 1'b1;
    instr_in = mk(10, 0, 0, 0); tick();
    instr_in = mk(11, 0, 0, 0); tick();
    instr_in = mk(0, 1, 2, 1);  tick();
    instr_in = mk(12, 0, 0, 0);
    sample();
    chk("jmp_outstanding2", 64'(outstanding), 64'd2);
    chk("jmp_wait", 64'(out_valid), 64'd0);
    chk("jmp_in_ready0", 64'(in_ready), 64'd0);
    wb_pulse(10);
    sample();
    chk("jmp_wait1", 64'(out_valid), 64'd0);
    wb_pulse(11);
    sample();
    chk("jmp_issue", 64'(out_valid), 64'd1);
    chk("jmp_is_jump", 64'(instr_out.jump), 64'd1);
    tick();
    in_valid = 1'b0;
    sample();
    chk("brwait_valid0", 64'(out_valid), 64'd0);
    chk("brwait_rd0_nocount", 64'(outstanding), 64'd0);
    chk("brwait_held12", 64'(instr_out.rd), 64'd12);
    tick();
    br_done = 1'b1;
    sample();
    chk("brwait_valid0b", 64'(out_valid), 64'd0);
    tick();
    br_done = 1'b0;
    sample();
    chk("brdone_issue", 64'(out_valid), 64'd1);
    tick();
    sample();
    chk("brdone_outstanding", 64'(outstanding), 64'd1);
    wb_pulse(12);

    // flush mid-stall
    in_valid = 1'b1;
    instr_in = mk(3, 1, 2, 0); tick();
    instr_in = mk(4, 3, 0, 0); tick();
    instr_in = mk(9, 0, 0, 0); flush = 1'b1;
    sample();
    chk("flush_in_ready0", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sample();
    chk("flush_valid0", 64'(out_valid), 64'd0);
    chk("flush_hold_free", 64'(in_ready), 64'd1);
    chk("flush_locks3", locks, 64'h8);
    chk("flush_outstanding", 64'(outstanding), 64'd1);
    wb_pulse(3);
    sample();
    chk("flush_wb_locks", locks, 64'd0);
    chk("flush_nothing_held", 64'(out_valid), 64'd0);

    // reset mid-operation with four writers outstanding and a held jump
    in_valid = 1'b1;
    for (int i = 20; i <= 23; i++) begin
      instr_in = mk(i, 0, 0, 0);
      tick();
    end
    instr_in = mk(1, 0, 0, 1); tick();
    in_valid = 1'b0;
    sample();
    chk("pre_rst_outstanding4", 64'(outstanding), 64'd4);
    #2 arst_ni = 1'b0;
    #1;
    chk("rst1_out_valid", 64'(out_valid), 64'd0);
    chk("rst1_in_ready", 64'(in_ready), 64'd1);
    chk("rst1_locks", locks, 64'd0);
    chk("rst1_outstanding", 64'(outstanding), 64'd0);
    chk("rst1_instr_out_zero", 64'(instr_out === '0), 64'd1);

    // reset while in BR_WAIT
    instr_in = mk(1, 0, 0, 1); in_valid = 1'b1;
    @(negedge clk); arst_ni = 1'b1;
    tick();
    instr_in = mk(2, 0, 0, 0);
    sample();
    chk("rst2_jal_valid", 64'(out_valid), 64'd1);
    tick();
    in_valid = 1'b0;
    sample();
    chk("rst2_brwait", 64'(out_valid), 64'd0);
    chk("rst2_outstanding1", 64'(outstanding), 64'd1);
    #2 arst_ni = 1'b0;
    #1;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    chk("rst2_locks", locks, 64'd0);
    chk("rst2_outstanding", 64'(outstanding), 64'd0);
    chk("rst2_instr_out_zero", 64'(instr_out === '0), 64'd1);

    // recovery: state is ISSUE again, first edge accepts
    instr_in = mk(2, 0, 0, 0); in_valid = 1'b1;
    @(negedge clk); arst_ni = 1'b1;
    tick();
    in_valid = 1'b0;
    sample();
    chk("recov_valid", 64'(out_valid), 64'd1);
    chk("recov_rd2", 64'(instr_out.rd), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv64g_issue_scoreboard.md
RV64G_ISSUE_SCOREBOARD -- requirements
Module: rv64g_issue_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default rv64g_pkg::NUM_OUTSTANDING (7): max issued-but-unretired register-writing instructions.
REQ-002 SHALL have ports clk_i and arst_ni: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk_i, input, 1: clock, all state on rising edge.
REQ-004 SHALL have port arst_ni, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port instr_in_i, input, decoded_instr_t: instruction from decoder.
REQ-006 SHALL have port instr_in_valid_i, input, 1, and port instr_in_ready_o, output, 1: decoder-side valid/ready.
REQ-007 SHALL have port instr_out_o, output, decoded_instr_t: instruction to execute units.
REQ-008 SHALL have port instr_out_valid_o, output, 1, and port instr_out_ready_i, input, 1: issue-side valid/ready.
REQ-009 SHALL have port wb_valid_i, input, 1, and port wb_rd_i, input, 6: writeback release of register wb_rd_i.
REQ-010 SHALL have port br_done_i, input, 1: issued jump/branch resolved.
REQ-011 SHALL have port flush_i, input, 1: discard held, unissued instruction.
REQ-012 SHALL have port locks_o, output, NUM_REGS: current lock vector.
REQ-013 SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING+1): current outstanding count.

Function
REQ-014 SHALL hold one instruction in a holding register; in-fire = valid & ready; out-fire = valid & ready.
REQ-015 SHALL drive instr_in_ready_o = !hold_valid | out-fire, giving full throughput; acceptance at cycle N makes instr_out_valid_o possible no earlier than N+1.
REQ-016 SHALL drive instr_out_o from the holding register only; instr_out_valid_o SHALL be a function of registered state only, with no combinational path from wb_valid_i or br_done_i.
REQ-017 SHALL assert instr_out_valid_o iff hold_valid, state==ISSUE, (reg_req & locks)==0, and outstanding < MAX_OUTSTANDING.
REQ-018 SHALL also require, for a held instruction with jump=1, outstanding==0 before asserting instr_out_valid_o.
REQ-019 SHALL, on out-fire with rd!=0, set locks[rd] and increment outstanding; rd==0 SHALL never lock or count.
REQ-020 SHALL, on wb_valid_i with locks[wb_rd_i]=1, clear locks[wb_rd_i] and decrement outstanding.
REQ-021 SHALL ignore wb_valid_i to an unlocked register, with no counter change and no underflow.
REQ-022 SHALL hold outstanding on simultaneous increment and decrement; a same-cycle lock and release of one register SHALL leave it locked.
REQ-023 SHALL make a register released at cycle N issuable at N+1 at the earliest, with no same-cycle bypass.
REQ-024 SHALL use FSM states ISSUE and BR_WAIT: ISSUE->BR_WAIT on out-fire of jump=1; BR_WAIT->ISSUE on br_done_i; in BR_WAIT, instr_out_valid_o=0 and input acceptance continues into a free holding register.
REQ-025 SHALL, on flush_i, clear hold_valid, force state to ISSUE, and keep locks and outstanding (in-flight work still writes back); flush SHALL win over a same-cycle in-fire, and instr_in_ready_o=0 during flush.
REQ-026 SHALL ignore br_done_i in ISSUE.

Reset
REQ-027 SHALL, while arst_ni=0, force hold_valid=0, state=ISSUE, locks=0, and outstanding=0, making instr_out_valid_o=0, instr_in_ready_o=1, locks_o=0, and outstanding_o=0; instr_out_o SHALL reset to all zeros.
REQ-028 SHALL discard any mid-operation reset state without replaying it; first acceptance SHALL occur on the first clk_i edge after arst_ni deasserts.

Structure
REQ-029 SHALL take decoded_instr_t, NUM_REGS, and NUM_OUTSTANDING from rv64g_pkg; enum issue_state_t {ISSUE, BR_WAIT} SHALL be added to rv64g_pkg.
REQ-030 SHALL place the lock vector, set/clear logic, and outstanding counter in sub-module rv64g_reg_lock_table; FSM and handshake SHALL stay in the top.

Verification
REQ-031 SHALL cover back-to-back independent issue: ADDI rd=5 then ADDI rd=6, ready=1 throughout -> issued on consecutive cycles, locks_o bits 5 and 6 set, outstanding_o=2.
REQ-032 SHALL cover a RAW stall: ADD rd=3 issued, then ADD rs1=3 held -> valid low until wb_rd_i=3 at cycle N, issue at N+1, outstanding_o 1->0->1.
REQ-033 SHALL cover the outstanding cap: 7 writes to rd=1..7 with no writeback -> 8th held with valid=0; one wb_rd_i=1 -> 8th issues next cycle.
REQ-034 SHALL cover a jump: BEQ held with outstanding_o=2 -> waits for two writebacks, issues, enters BR_WAIT; next ADDI held until br_done_i, issues the following cycle.
REQ-035 SHALL cover flush mid-stall: ADD rs1=3 held on locked x3, flush_i=1 -> hold cleared, locks_o[3] still 1, later wb_rd_i=3 clears it.
REQ-036 SHALL cover reset mid-operation: arst_ni low with outstanding_o=4 and BR_WAIT -> all outputs at reset values immediately, before the next clk_i edge.
